// File: rtl/ex_wb_arbiter.sv
// ex_wb_arbiter: schedules the two EX writeback lanes among ALU lane 0,
// ALU lane 1, the MDU and the FPU, and registers the winners into writeback.
// The MDU prefers lane 1. The FPU only ever uses lane 0. A round-robin pointer
// decides when both units contend for lane 0. Per-unit starvation counters
// raise issue_stall_x so that a long-latency result can win a lane.
// Optional feature macro: EX_WB_ARB_PERF_EN adds the perf_conflict_cnt output.
module ex_wb_arbiter #(
    parameter int DATA_WIDTH   = 64,
    parameter int RD_WIDTH     = 5,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  alu_valid_0,
    input  logic [DATA_WIDTH-1:0] alu_data_0,
    input  logic [RD_WIDTH-1:0]   alu_rd_0,
    input  logic                  alu_valid_1,
    input  logic [DATA_WIDTH-1:0] alu_data_1,
    input  logic [RD_WIDTH-1:0]   alu_rd_1,
    input  logic                  mdu_valid,
    input  logic [DATA_WIDTH-1:0] mdu_data,
    input  logic [RD_WIDTH-1:0]   mdu_rd,
    output logic                  mdu_ready,
    input  logic                  fpu_valid,
    input  logic [DATA_WIDTH-1:0] fpu_data,
    input  logic [RD_WIDTH-1:0]   fpu_rd,
    output logic                  fpu_ready,
    output logic                  issue_stall_0,
    output logic                  issue_stall_1,
    output logic                  wb_valid_0,
    output logic [DATA_WIDTH-1:0] wb_data_0,
    output logic [RD_WIDTH-1:0]   wb_rd_0,
    output logic [1:0]            wb_src_0,
    output logic                  wb_valid_1,
    output logic [DATA_WIDTH-1:0] wb_data_1,
    output logic [RD_WIDTH-1:0]   wb_rd_1,
    output logic [1:0]            wb_src_1
`ifdef EX_WB_ARB_PERF_EN
    ,
    output logic [31:0]           perf_conflict_cnt
`endif
);

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_ALU  = 2'b01,
        SRC_MDU  = 2'b10,
        SRC_FPU  = 2'b11
    } src_e;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic                  rr_ptr;       // 0 = FPU favoured, 1 = MDU favoured
    logic [7:0]            mdu_cnt, fpu_cnt;
    logic [7:0]            mdu_cnt_nxt, fpu_cnt_nxt;
    logic                  conflict, conflict_gnt, fpu_wins;
    logic                  mdu_gnt_0, mdu_gnt_1, fpu_gnt_0;
    logic                  mdu_hs, fpu_hs;
    logic                  nxt_valid_0, nxt_valid_1;
    logic [DATA_WIDTH-1:0] nxt_data_0, nxt_data_1;
    logic [RD_WIDTH-1:0]   nxt_rd_0, nxt_rd_1;
    logic [1:0]            nxt_src_0, nxt_src_1;

    // Lane grants. A starving FPU overrides the round-robin pointer on lane 0.
    always_comb begin
        conflict     = mdu_valid && fpu_valid && alu_valid_1 && !alu_valid_0;
        fpu_wins     = issue_stall_0 || !rr_ptr;
        conflict_gnt = conflict && !flush;
        mdu_gnt_1    = !flush && mdu_valid && !alu_valid_1;
        fpu_gnt_0    = !flush && fpu_valid && !alu_valid_0 && (!conflict || fpu_wins);
        mdu_gnt_0    = !flush && mdu_valid && alu_valid_1 && !alu_valid_0 && !fpu_gnt_0;
        mdu_ready    = mdu_gnt_0 || mdu_gnt_1;
        fpu_ready    = fpu_gnt_0;
        mdu_hs       = mdu_valid && mdu_ready;
        fpu_hs       = fpu_valid && fpu_ready;
        mdu_cnt_nxt  = '0;
        fpu_cnt_nxt  = '0;
        if (mdu_valid && !mdu_ready) begin
            mdu_cnt_nxt = (mdu_cnt == 8'hFF) ? mdu_cnt : mdu_cnt + 8'd1;
        end
        if (fpu_valid && !fpu_ready) begin
            fpu_cnt_nxt = (fpu_cnt == 8'hFF) ? fpu_cnt : fpu_cnt + 8'd1;
        end
    end

    // Next writeback contents per lane; ALU always owns its own lane.
    always_comb begin
        nxt_valid_0 = 1'b0;
        nxt_data_0  = '0;
        nxt_rd_0    = '0;
        nxt_src_0   = SRC_NONE;
        nxt_valid_1 = 1'b0;
        nxt_data_1  = '0;
        nxt_rd_1    = '0;
        nxt_src_1   = SRC_NONE;
        if (!flush) begin
            if (alu_valid_0) begin
                nxt_valid_0 = 1'b1;
                nxt_data_0  = alu_data_0;
                nxt_rd_0    = alu_rd_0;
                nxt_src_0   = SRC_ALU;
            end else if (fpu_gnt_0) begin
                nxt_valid_0 = 1'b1;
                nxt_data_0  = fpu_data;
                nxt_rd_0    = fpu_rd;
                nxt_src_0   = SRC_FPU;
            end else if (mdu_gnt_0) begin
                nxt_valid_0 = 1'b1;
                nxt_data_0  = mdu_data;
                nxt_rd_0    = mdu_rd;
                nxt_src_0   = SRC_MDU;
            end
            if (alu_valid_1) begin
                nxt_valid_1 = 1'b1;
                nxt_data_1  = alu_data_1;
                nxt_rd_1    = alu_rd_1;
                nxt_src_1   = SRC_ALU;
            end else if (mdu_gnt_1) begin
                nxt_valid_1 = 1'b1;
                nxt_data_1  = mdu_data;
                nxt_rd_1    = mdu_rd;
                nxt_src_1   = SRC_MDU;
            end
        end
    end

    // Writeback pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_0 <= 1'b0;
            wb_data_0  <= '0;
            wb_rd_0    <= '0;
            wb_src_0   <= SRC_NONE;
            wb_valid_1 <= 1'b0;
            wb_data_1  <= '0;
            wb_rd_1    <= '0;
            wb_src_1   <= SRC_NONE;
        end else begin
            wb_valid_0 <= nxt_valid_0;
            wb_data_0  <= nxt_data_0;
            wb_rd_0    <= nxt_rd_0;
            wb_src_0   <= nxt_src_0;
            wb_valid_1 <= nxt_valid_1;
            wb_data_1  <= nxt_data_1;
            wb_rd_1    <= nxt_rd_1;
            wb_src_1   <= nxt_src_1;
        end
    end

    // Round-robin pointer moves to the loser after each contended grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (conflict_gnt) begin
            rr_ptr <= fpu_wins;
        end
    end

    // Starvation counters and sticky issue stalls (released by the handshake).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdu_cnt       <= '0;
            fpu_cnt       <= '0;
            issue_stall_0 <= 1'b0;
            issue_stall_1 <= 1'b0;
        end else if (flush) begin
            mdu_cnt       <= '0;
            fpu_cnt       <= '0;
            issue_stall_0 <= 1'b0;
            issue_stall_1 <= 1'b0;
        end else begin
            mdu_cnt <= mdu_cnt_nxt;
            fpu_cnt <= fpu_cnt_nxt;
            if (fpu_hs) begin
                issue_stall_0 <= 1'b0;
            end else if (fpu_cnt_nxt >= LIMIT) begin
                issue_stall_0 <= 1'b1;
            end
            if (mdu_hs) begin
                issue_stall_1 <= 1'b0;
            end else if (mdu_cnt_nxt >= LIMIT) begin
                issue_stall_1 <= 1'b1;
            end
        end
    end

`ifdef EX_WB_ARB_PERF_EN
    // Cycles lost to lane contention or requested bubbles; flush leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_conflict_cnt <= '0;
        end else if (conflict_gnt || issue_stall_0 || issue_stall_1) begin
            perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_wb_arbiter.sv
// Testbench for ex_wb_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_ex_wb_arbiter;
    localparam int DW    = 64;
    localparam int RW    = 5;
    localparam int LIMIT = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          alu_valid_0 = 1'b0, alu_valid_1 = 1'b0;
    logic [DW-1:0] alu_data_0 = '0, alu_data_1 = '0;
    logic [RW-1:0] alu_rd_0 = '0, alu_rd_1 = '0;
    logic          mdu_valid = 1'b0, fpu_valid = 1'b0;
    logic [DW-1:0] mdu_data = '0, fpu_data = '0;
    logic [RW-1:0] mdu_rd = '0, fpu_rd = '0;
    logic          mdu_ready, fpu_ready;
    logic          issue_stall_0, issue_stall_1;
    logic          wb_valid_0, wb_valid_1;
    logic [DW-1:0] wb_data_0, wb_data_1;
    logic [RW-1:0] wb_rd_0, wb_rd_1;
    logic [1:0]    wb_src_0, wb_src_1;
`ifdef EX_WB_ARB_PERF_EN
    logic [31:0]   perf_conflict_cnt;
`endif

    ex_wb_arbiter #(.DATA_WIDTH(DW), .RD_WIDTH(RW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alu_valid_0(alu_valid_0), .alu_data_0(alu_data_0), .alu_rd_0(alu_rd_0),
        .alu_valid_1(alu_valid_1), .alu_data_1(alu_data_1), .alu_rd_1(alu_rd_1),
        .mdu_valid(mdu_valid), .mdu_data(mdu_data), .mdu_rd(mdu_rd), .mdu_ready(mdu_ready),
        .fpu_valid(fpu_valid), .fpu_data(fpu_data), .fpu_rd(fpu_rd), .fpu_ready(fpu_ready),
        .issue_stall_0(issue_stall_0), .issue_stall_1(issue_stall_1),
        .wb_valid_0(wb_valid_0), .wb_data_0(wb_data_0), .wb_rd_0(wb_rd_0), .wb_src_0(wb_src_0),
        .wb_valid_1(wb_valid_1), .wb_data_1(wb_data_1), .wb_rd_1(wb_rd_1), .wb_src_1(wb_src_1)
`ifdef EX_WB_ARB_PERF_EN
        , .perf_conflict_cnt(perf_conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: lane owners as a small per-lane "who writes" decision.
    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic [RW-1:0] r;
        logic [1:0]    s;
    } wb_t;

    wb_t         e0, e1;
    int          m_rr;          // 0: FPU next on contention, 1: MDU next
    int          m_wait_m, m_wait_f;
    bit          m_st0, m_st1;
    logic [31:0] m_perf;

    function automatic wb_t mk(input logic [DW-1:0] d, input logic [RW-1:0] r, input logic [1:0] s);
        wb_t w;
        w.v = 1'b1; w.d = d; w.r = r; w.s = s;
        return w;
    endfunction

    function automatic wb_t none();
        wb_t w;
        w.v = 1'b0; w.d = '0; w.r = '0; w.s = 2'b00;
        return w;
    endfunction

    always @(negedge clk) begin
        bit g_m, g_f, g_m_lane1, contended, stall_step;
        if (rst) begin
            e0 = none(); e1 = none();
            m_rr = 0; m_wait_m = 0; m_wait_f = 0; m_st0 = 0; m_st1 = 0; m_perf = '0;
        end else begin
            chk("wb_valid_0", wb_valid_0, e0.v);
            chk("wb_data_0",  wb_data_0,  e0.d);
            chk("wb_rd_0",    wb_rd_0,    e0.r);
            chk("wb_src_0",   wb_src_0,   e0.s);
            chk("wb_valid_1", wb_valid_1, e1.v);
            chk("wb_data_1",  wb_data_1,  e1.d);
            chk("wb_rd_1",    wb_rd_1,    e1.r);
            chk("wb_src_1",   wb_src_1,   e1.s);
            chk("issue_stall_0", issue_stall_0, m_st0);
            chk("issue_stall_1", issue_stall_1, m_st1);
`ifdef EX_WB_ARB_PERF_EN
            chk("perf_conflict_cnt", perf_conflict_cnt, m_perf);
`endif
            g_m = 0; g_f = 0; g_m_lane1 = 0; contended = 0;
            if (!flush) begin
                if (mdu_valid && !alu_valid_1) begin g_m = 1; g_m_lane1 = 1; end
                if (!alu_valid_0) begin
                    if (fpu_valid && mdu_valid && !g_m) begin
                        contended = 1;
                        if (m_st0 || m_rr == 0) begin g_f = 1; m_rr = 1; end
                        else begin g_m = 1; m_rr = 0; end
                    end else begin
                        g_f = fpu_valid;
                        if (mdu_valid && !g_m) g_m = 1;
                    end
                end
            end
            chk("mdu_ready", mdu_ready, g_m);
            chk("fpu_ready", fpu_ready, g_f);
            stall_step = contended || m_st0 || m_st1;
            if (stall_step) m_perf = m_perf + 32'd1;
            if (flush) begin
                e0 = none(); e1 = none();
                m_wait_m = 0; m_wait_f = 0; m_st0 = 0; m_st1 = 0;
            end else begin
                e0 = alu_valid_0 ? mk(alu_data_0, alu_rd_0, 2'b01) :
                     g_f ? mk(fpu_data, fpu_rd, 2'b11) :
                     (g_m && !g_m_lane1) ? mk(mdu_data, mdu_rd, 2'b10) : none();
                e1 = alu_valid_1 ? mk(alu_data_1, alu_rd_1, 2'b01) :
                     g_m_lane1 ? mk(mdu_data, mdu_rd, 2'b10) : none();
                m_wait_m = (mdu_valid && !g_m) ? ((m_wait_m < 255) ? m_wait_m + 1 : 255) : 0;
                m_wait_f = (fpu_valid && !g_f) ? ((m_wait_f < 255) ? m_wait_f + 1 : 255) : 0;
                if (fpu_valid && g_f) m_st0 = 0;
                else if (m_wait_f >= LIMIT) m_st0 = 1;
                if (mdu_valid && g_m) m_st1 = 0;
                else if (m_wait_m >= LIMIT) m_st1 = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0;
        alu_valid_0 = 0; alu_valid_1 = 0; mdu_valid = 0; fpu_valid = 0;
        alu_data_0 = '0; alu_data_1 = '0; alu_rd_0 = '0; alu_rd_1 = '0;
        mdu_data = '0; fpu_data = '0; mdu_rd = '0; fpu_rd = '0;
    endtask

    task automatic quiesce();
        step(); idle(); flush = 1;
        step(); flush = 0;
    endtask

    // Block lane(s) until the unit starves, then free its lane.
    task automatic starve(input bit is_fpu);
        alu_valid_0 = 1; alu_data_0 = 64'hA0; alu_valid_1 = 1; alu_data_1 = 64'hA1;
        if (is_fpu) begin fpu_valid = 1; fpu_data = 64'hF00D; fpu_rd = 5'd9; end
        else        begin mdu_valid = 1; mdu_data = 64'hBEEF; mdu_rd = 5'd12; end
        for (int i = 0; i < LIMIT; i++) begin
            step(); #1;
            if (is_fpu) chk("stall0_rise", issue_stall_0, (i == LIMIT - 1));
            else        chk("stall1_rise", issue_stall_1, (i == LIMIT - 1));
        end
        if (is_fpu) alu_valid_0 = 0; else alu_valid_1 = 0;
        #1;
        if (is_fpu) chk("starved_fpu_ready", fpu_ready, 1'b1);
        else        chk("starved_mdu_ready", mdu_ready, 1'b1);
        step(); idle(); #1;
        if (is_fpu) begin
            chk("stall0_clear", issue_stall_0, 1'b0);
            chk("fpu_wb_src0", wb_src_0, 2'b11);
        end else begin
            chk("stall1_clear", issue_stall_1, 1'b0);
            chk("mdu_wb_src1", wb_src_1, 2'b10);
        end
    endtask

    initial begin
        bit hs_m, hs_f;
        idle();
        rst = 1;
        repeat (2) @(negedge clk);
        step(); rst = 0;

        // ALU only
        step();
        alu_valid_0 = 1; alu_data_0 = 64'h11; alu_rd_0 = 5'd3;
        alu_valid_1 = 1; alu_data_1 = 64'h22; alu_rd_1 = 5'd7;
        #1;
        chk("alu_only_mdu_ready", mdu_ready, 1'b0);
        chk("alu_only_fpu_ready", fpu_ready, 1'b0);
        step(); idle(); #1;
        chk("alu_wb_valid_0", wb_valid_0, 1'b1);
        chk("alu_wb_data_0", wb_data_0, 64'h11);
        chk("alu_wb_rd_0", wb_rd_0, 5'd3);
        chk("alu_wb_src_0", wb_src_0, 2'b01);
        chk("alu_wb_data_1", wb_data_1, 64'h22);
        chk("alu_wb_src_1", wb_src_1, 2'b01);

        // Both lanes free, MDU and FPU valid
        step();
        mdu_valid = 1; mdu_data = 64'h33; mdu_rd = 5'd4;
        fpu_valid = 1; fpu_data = 64'h44; fpu_rd = 5'd5;
        #1;
        chk("free_mdu_ready", mdu_ready, 1'b1);
        chk("free_fpu_ready", fpu_ready, 1'b1);
        step(); idle(); #1;
        chk("free_wb_src_1", wb_src_1, 2'b10);
        chk("free_wb_src_0", wb_src_0, 2'b11);
        chk("free_wb_data_1", wb_data_1, 64'h33);

        // Lane 1 busy, contention on lane 0 over three cycles
        alu_valid_1 = 1; alu_data_1 = 64'h55;
        mdu_valid = 1; mdu_data = 64'h66; fpu_valid = 1; fpu_data = 64'h77;
        #1;
        chk("conf1_fpu_ready", fpu_ready, 1'b1);
        chk("conf1_mdu_ready", mdu_ready, 1'b0);
        step(); fpu_data = 64'h78; #1;
        chk("conf2_mdu_ready", mdu_ready, 1'b1);
        chk("conf2_fpu_ready", fpu_ready, 1'b0);
        chk("conf1_wb_src_0", wb_src_0, 2'b11);
        step(); mdu_data = 64'h67; #1;
        chk("conf3_fpu_ready", fpu_ready, 1'b1);
        chk("conf2_wb_data_0", wb_data_0, 64'h66);
        step(); idle();

        // Randomized traffic; MDU/FPU hold a result until it is accepted
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            hs_m = mdu_valid && mdu_ready;
            hs_f = fpu_valid && fpu_ready;
            step();
            flush = ($urandom_range(0, 31) == 0);
            alu_valid_0 = !issue_stall_0 && ($urandom_range(0, 9) < 7);
            alu_valid_1 = !issue_stall_1 && ($urandom_range(0, 9) < 7);
            alu_data_0 = {$urandom, $urandom}; alu_rd_0 = RW'($urandom);
            alu_data_1 = {$urandom, $urandom}; alu_rd_1 = RW'($urandom);
            if (!mdu_valid || hs_m) begin
                mdu_valid = ($urandom_range(0, 2) != 0);
                mdu_data = {$urandom, $urandom}; mdu_rd = RW'($urandom);
            end
            if (!fpu_valid || hs_f) begin
                fpu_valid = ($urandom_range(0, 2) != 0);
                fpu_data = {$urandom, $urandom}; fpu_rd = RW'($urandom);
            end
        end

        quiesce(); starve(1'b1);
        quiesce(); starve(1'b0);

        // Flush with MDU valid on a free lane
        quiesce();
        mdu_valid = 1; mdu_data = 64'h99; mdu_rd = 5'd2; flush = 1;
        #1;
        chk("flush_mdu_ready", mdu_ready, 1'b0);
        step(); flush = 0; #1;
        chk("flush_wb_valid_0", wb_valid_0, 1'b0);
        chk("flush_wb_valid_1", wb_valid_1, 1'b0);
        chk("post_flush_mdu_ready", mdu_ready, 1'b1);
        step(); idle(); #1;
        chk("post_flush_wb_src_1", wb_src_1, 2'b10);

        // Asynchronous reset mid-cycle
        alu_valid_0 = 1; alu_data_0 = 64'hAB;
        step(); idle(); #1;
        chk("pre_rst_wb_valid_0", wb_valid_0, 1'b1);
        #1; rst = 1; #1;
        chk("rst_wb_valid_0", wb_valid_0, 1'b0);
        chk("rst_issue_stall_0", issue_stall_0, 1'b0);
        chk("rst_issue_stall_1", issue_stall_1, 1'b0);
`ifdef EX_WB_ARB_PERF_EN
        chk("rst_perf", perf_conflict_cnt, 32'd0);
`endif
        step(); rst = 0;
        repeat (3) step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
